// File: rtl/board_io_pkg.sv
// ---------------------------------------------------------------------------
// board_io_pkg
//   Constants shared by the board I/O conditioning logic.
//   DEFAULT_DEBOUNCE_CYCLES : 10 ms filter window at 25 MHz
//   SIM_DEBOUNCE_CYCLES     : short window for simulation runs
//   NUM_SWITCHES            : number of push-buttons on the board
// ---------------------------------------------------------------------------
package board_io_pkg;

    localparam int DEFAULT_DEBOUNCE_CYCLES = 250000;
    localparam int SIM_DEBOUNCE_CYCLES     = 4;
    localparam int NUM_SWITCHES            = 4;

endpackage : board_io_pkg

// File: rtl/debounce_channel.sv
// ---------------------------------------------------------------------------
// debounce_channel
//   One switch input: 2-flop synchroniser, counter-based debounce filter,
//   registered stable level and one-cycle rise/fall pulses.
//
//   Ports:
//     clk        : system clock (CPU clock domain)
//     rst_n      : asynchronous active-low reset
//     switch_raw : raw, asynchronous, bouncing switch level
//     level      : debounced stable level
//     rise       : one-cycle pulse in the cycle level first reads 1
//     fall       : one-cycle pulse in the cycle level first reads 0
//
//   The output follows the synchronised input only after it has disagreed
//   with the current level on DEBOUNCE_CYCLES consecutive edges. Any single
//   edge of agreement restarts the run. DEBOUNCE_CYCLES must be >= 2.
// ---------------------------------------------------------------------------
module debounce_channel
    import board_io_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = DEFAULT_DEBOUNCE_CYCLES
) (
    input  logic clk,
    input  logic rst_n,
    input  logic switch_raw,
    output logic level,
    output logic rise,
    output logic fall
);

    localparam int                 CNT_W   = $clog2(DEBOUNCE_CYCLES);
    localparam logic [CNT_W-1:0]   CNT_MAX = CNT_W'(DEBOUNCE_CYCLES - 1);

    logic             sync1;
    logic             sync2;
    logic [CNT_W-1:0] cnt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync1 <= 1'b0;
            sync2 <= 1'b0;
            level <= 1'b0;
            cnt   <= '0;
            rise  <= 1'b0;
            fall  <= 1'b0;
        end else begin
            sync1 <= switch_raw;
            sync2 <= sync1;

            if (sync2 == level) begin
                // Agreement anywhere in the run throws the run away.
                cnt  <= '0;
                rise <= 1'b0;
                fall <= 1'b0;
            end else if (cnt == CNT_MAX) begin
                // This edge is the DEBOUNCE_CYCLES-th consecutive
                // disagreement: accept the new level and pulse once.
                level <= sync2;
                cnt   <= '0;
                rise  <= sync2;
                fall  <= ~sync2;
            end else begin
                // Saturating by construction: the branch above catches
                // CNT_MAX before an increment could wrap.
                cnt  <= cnt + 1'b1;
                rise <= 1'b0;
                fall <= 1'b0;
            end
        end
    end

endmodule : debounce_channel

// File: rtl/switch_debouncer.sv
// ---------------------------------------------------------------------------
// switch_debouncer
//   Conditions NUM_CH raw push-button inputs for use in the CPU clock domain.
//   Each channel is an independent debounce_channel instance.
//
//   Ports:
//     i_Clk    : system clock, same as the CPU
//     i_Rst_n  : asynchronous active-low reset
//     i_Switch : raw switch levels, bit n is switch n+1
//     o_Level  : debounced stable level per channel
//     o_Rise   : one-cycle pulse per channel on a 0->1 level change
//     o_Fall   : one-cycle pulse per channel on a 1->0 level change
//
//   Latency from the edge that first samples a new stable raw value to the
//   new o_Level is DEBOUNCE_CYCLES+1 edges. All outputs are registered.
// ---------------------------------------------------------------------------
module switch_debouncer
    import board_io_pkg::*;
#(
    parameter int NUM_CH          = NUM_SWITCHES,
    parameter int DEBOUNCE_CYCLES = DEFAULT_DEBOUNCE_CYCLES
) (
    input  logic              i_Clk,
    input  logic              i_Rst_n,
    input  logic [NUM_CH-1:0] i_Switch,
    output logic [NUM_CH-1:0] o_Level,
    output logic [NUM_CH-1:0] o_Rise,
    output logic [NUM_CH-1:0] o_Fall
);

    // Counter width is derived from the filter window.
    localparam int CNT_W = $clog2(DEBOUNCE_CYCLES);

    for (genvar n = 0; n < NUM_CH; n++) begin : g_ch
        debounce_channel #(
            .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES)
        ) u_ch (
            .clk        (i_Clk),
            .rst_n      (i_Rst_n),
            .switch_raw (i_Switch[n]),
            .level      (o_Level[n]),
            .rise       (o_Rise[n]),
            .fall       (o_Fall[n])
        );
    end

endmodule : switch_debouncer

// File: tb/tb_switch_debouncer.sv
// ---------------------------------------------------------------------------
// tb_switch_debouncer
//   Directed bench for switch_debouncer with DEBOUNCE_CYCLES = 4, so a new
//   level is expected just after E5 (E0 = edge that first samples it).
//   Inputs change 1 time unit after a rising edge, outputs are read there.
// ---------------------------------------------------------------------------
module tb_switch_debouncer;
    import board_io_pkg::*;

    localparam int NCH = NUM_SWITCHES;

    // ---------------- clock / reset ----------------
    logic           clk = 1'b0;
    logic           rst_n = 1'b0;
    logic [NCH-1:0] sw = '0;
    logic [NCH-1:0] level;
    logic [NCH-1:0] rise;
    logic [NCH-1:0] fall;

    int n_cmp  = 0;
    int n_fail = 0;

    always #5 clk = ~clk;

    switch_debouncer #(
        .NUM_CH          (NCH),
        .DEBOUNCE_CYCLES (SIM_DEBOUNCE_CYCLES)
    ) dut (
        .i_Clk    (clk),
        .i_Rst_n  (rst_n),
        .i_Switch (sw),
        .o_Level  (level),
        .o_Rise   (rise),
        .o_Fall   (fall)
    );

    // ---------------- driver tasks ----------------
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        sw    = '0;
        rst_n = 1'b0;
        tick();
        tick();
        rst_n = 1'b1;
    endtask

    // ---------------- scenarios ----------------
    task automatic test_reset();
        sw    = '0;
        rst_n = 1'b0;
        #2;
        n_cmp++;
        if ({level, rise, fall} !== 12'h000) begin
            n_fail++;
            $display("FAIL reset_async: got %h want 000", {level, rise, fall});
        end
        tick();
        tick();
        rst_n = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            n_cmp++;
            if ({level, rise, fall} !== 12'h000) begin
                n_fail++;
                $display("FAIL reset_idle c%0d: got %h want 000", i, {level, rise, fall});
            end
        end
    endtask

    task automatic test_clean_press();
        do_reset();
        sw = 4'b0001;
        for (int e = 0; e <= 4; e++) begin
            tick();
            n_cmp++;
            if ({level, rise, fall} !== 12'h000) begin
                n_fail++;
                $display("FAIL press_wait E%0d: got %h want 000", e, {level, rise, fall});
            end
        end
        tick();  // E5
        n_cmp++;
        if ({level, rise, fall} !== 12'h110) begin
            n_fail++;
            $display("FAIL press_E5: got %h want 110", {level, rise, fall});
        end
        for (int i = 0; i < 4; i++) begin
            tick();
            n_cmp++;
            if ({level, rise, fall} !== 12'h100) begin
                n_fail++;
                $display("FAIL press_hold c%0d: got %h want 100", i, {level, rise, fall});
            end
        end
    endtask

    task automatic test_glitch();
        do_reset();
        sw = 4'b0010;
        tick();
        tick();
        tick();
        sw = 4'b0000;
        for (int i = 0; i < 10; i++) begin
            tick();
            n_cmp++;
            if ({level, rise, fall} !== 12'h000) begin
                n_fail++;
                $display("FAIL glitch c%0d: got %h want 000", i, {level, rise, fall});
            end
        end
    endtask

    task automatic test_bounce();
        logic [4:0] pattern;
        int         rise_cnt;
        pattern  = 5'b10101;
        rise_cnt = 0;
        do_reset();
        // Toggles 1,0,1,0,1; the last tick here is E0 of the final value.
        for (int i = 4; i >= 0; i--) begin
            sw = {1'b0, pattern[i], 2'b00};
            tick();
            if (rise[2]) rise_cnt++;
            n_cmp++;
            if (level !== 4'b0000) begin
                n_fail++;
                $display("FAIL bounce_toggle t%0d: level %b want 0000", i, level);
            end
        end
        for (int e = 1; e <= 4; e++) begin
            tick();
            if (rise[2]) rise_cnt++;
            n_cmp++;
            if (level !== 4'b0000) begin
                n_fail++;
                $display("FAIL bounce_wait E%0d: level %b want 0000", e, level);
            end
        end
        tick();  // E5
        if (rise[2]) rise_cnt++;
        n_cmp++;
        if ({level, rise} !== 8'h44) begin
            n_fail++;
            $display("FAIL bounce_E5: level/rise %h want 44", {level, rise});
        end
        for (int i = 0; i < 6; i++) begin
            tick();
            if (rise[2]) rise_cnt++;
        end
        n_cmp++;
        if (rise_cnt !== 1) begin
            n_fail++;
            $display("FAIL bounce_rise_count: got %0d want 1", rise_cnt);
        end
    endtask

    task automatic test_release();
        do_reset();
        sw = 4'b1000;
        for (int i = 0; i < 8; i++) tick();
        n_cmp++;
        if ({level, rise, fall} !== 12'h800) begin
            n_fail++;
            $display("FAIL release_setup: got %h want 800", {level, rise, fall});
        end
        sw = 4'b0000;
        for (int e = 0; e <= 4; e++) begin
            tick();
            n_cmp++;
            if ({level, rise, fall} !== 12'h800) begin
                n_fail++;
                $display("FAIL release_wait E%0d: got %h want 800", e, {level, rise, fall});
            end
        end
        tick();  // E5
        n_cmp++;
        if ({level, rise, fall} !== 12'h008) begin
            n_fail++;
            $display("FAIL release_E5: got %h want 008", {level, rise, fall});
        end
        for (int i = 0; i < 3; i++) begin
            tick();
            n_cmp++;
            if ({level, rise, fall} !== 12'h000) begin
                n_fail++;
                $display("FAIL release_after c%0d: got %h want 000", i, {level, rise, fall});
            end
        end
    endtask

    task automatic test_simultaneous();
        do_reset();
        sw = 4'b1111;
        for (int e = 0; e <= 4; e++) begin
            tick();
            n_cmp++;
            if ({level, rise, fall} !== 12'h000) begin
                n_fail++;
                $display("FAIL simul_wait E%0d: got %h want 000", e, {level, rise, fall});
            end
        end
        tick();  // E5
        n_cmp++;
        if ({level, rise, fall} !== 12'hff0) begin
            n_fail++;
            $display("FAIL simul_E5: got %h want ff0", {level, rise, fall});
        end
        tick();
        n_cmp++;
        if ({level, rise, fall} !== 12'hf00) begin
            n_fail++;
            $display("FAIL simul_E6: got %h want f00", {level, rise, fall});
        end
    endtask

    task automatic test_reset_mid_count();
        do_reset();
        // Bring channel 1 high first so the async clear is observable.
        sw = 4'b0010;
        for (int i = 0; i < 8; i++) tick();
        n_cmp++;
        if (level !== 4'b0010) begin
            n_fail++;
            $display("FAIL rmc_setup: level %b want 0010", level);
        end
        sw = 4'b0011;
        tick();  // E0
        tick();  // E1
        tick();  // E2, cnt=1
        tick();  // E3, cnt=2
        #2;
        rst_n = 1'b0;
        #1;
        n_cmp++;
        if ({level, rise, fall} !== 12'h000) begin
            n_fail++;
            $display("FAIL rmc_async_clear: got %h want 000", {level, rise, fall});
        end
        for (int i = 0; i < 3; i++) begin
            tick();
            n_cmp++;
            if ({level, rise, fall} !== 12'h000) begin
                n_fail++;
                $display("FAIL rmc_in_reset c%0d: got %h want 000", i, {level, rise, fall});
            end
        end
        sw    = 4'b0001;
        rst_n = 1'b1;
        for (int e = 0; e <= 4; e++) begin
            tick();
            n_cmp++;
            if ({level, rise, fall} !== 12'h000) begin
                n_fail++;
                $display("FAIL rmc_wait E%0d: got %h want 000", e, {level, rise, fall});
            end
        end
        tick();  // E5
        n_cmp++;
        if ({level, rise, fall} !== 12'h110) begin
            n_fail++;
            $display("FAIL rmc_E5: got %h want 110", {level, rise, fall});
        end
    endtask

    // ---------------- sequence and report ----------------
    initial begin
        test_reset();
        test_clean_press();
        test_glitch();
        test_bounce();
        test_release();
        test_simultaneous();
        test_reset_mid_count();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule : tb_switch_debouncer
